keccak_dom_prng: RTL

- Upstream randomness source for the masked Keccak chi stage; generates the fresh mask bits that stage consumes on its ZxDI input every clock.
- A bank of 32-bit LFSRs is seeded word by word over a valid/ready handshake, warmed up, then advanced once per enabled cycle.
- Output width matches the chi stage's randomness input exactly for the same SHARES value.

---
 rtl/keccak_dom_prng.sv | 114 +++++++++++
 1 files changed

// File: rtl/keccak_dom_prng.sv
// Mask-bit source for the masked Keccak chi stage: a bank of 32-bit LFSRs that are
// seeded over a valid/ready handshake, warmed up, then advanced once per enabled cycle.
module keccak_dom_prng #(
    parameter int SHARES        = 6,
    parameter int WARMUP_CYCLES = 16,
    localparam int NUM_Z        = (SHARES * SHARES - SHARES) / 2 * 5,
    localparam int LFSR_CNT     = (NUM_Z + 31) / 32
) (
    input  logic             ClkxCI,
    input  logic             RstxRBI,
    input  logic [31:0]      SeedxDI,
    input  logic             SeedValidxSI,
    output logic             SeedReadyxSO,
    input  logic             ReseedxSI,
    input  logic             EnxSI,
    output logic [NUM_Z-1:0] ZxDO,
    output logic             ZValidxSO
);

    localparam int CNT_W = (LFSR_CNT > 1) ? $clog2(LFSR_CNT) : 1;

    localparam logic [1:0] StSeed   = 2'd0;
    localparam logic [1:0] StWarmup = 2'd1;
    localparam logic [1:0] StRun    = 2'd2;

    logic [1:0]                 state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [7:0]                 wcnt_q, wcnt_d;
    logic [LFSR_CNT-1:0][31:0]  lfsr_q, lfsr_d;
    logic [LFSR_CNT*32-1:0]     lfsr_flat;
    logic                       advance;

    // 32 unrolled steps so every output bit is fresh after one advance.
    function automatic logic [31:0] lfsr_adv(input logic [31:0] s);
        logic [31:0] t;
        t = s;
        for (int i = 0; i < 32; i++) begin
            t = {t[30:0], t[31] ^ t[21] ^ t[1] ^ t[0]};
        end
        return t;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wcnt_d  = wcnt_q;
        lfsr_d  = lfsr_q;
        advance = 1'b0;
        case (state_q)
            StSeed: begin
                if (SeedValidxSI) begin
                    for (int i = 0; i < LFSR_CNT; i++) begin
                        // Zero seeds would lock the register; the step map is a
                        // bijection, so a nonzero state never reaches zero.
                        if (cnt_q == CNT_W'(i)) begin
                            lfsr_d[i] = (SeedxDI == 32'h0) ? 32'h0000_0001 : SeedxDI;
                        end
                    end
                    if (cnt_q == CNT_W'(LFSR_CNT - 1)) begin
                        state_d = StWarmup;
                        cnt_d   = '0;
                        wcnt_d  = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StWarmup: begin
                advance = 1'b1;
                if (wcnt_q == 8'(WARMUP_CYCLES - 1)) begin
                    state_d = StRun;
                end else begin
                    wcnt_d = wcnt_q + 8'd1;
                end
            end
            StRun: begin
                advance = EnxSI;
                if (ReseedxSI) begin
                    state_d = StSeed;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = StSeed;
                cnt_d   = '0;
            end
        endcase
        if (advance) begin
            for (int i = 0; i < LFSR_CNT; i++) begin
                lfsr_d[i] = lfsr_adv(lfsr_q[i]);
            end
        end
    end

    always_ff @(posedge ClkxCI or negedge RstxRBI) begin
        if (!RstxRBI) begin
            state_q <= StSeed;
            cnt_q   <= '0;
            wcnt_q  <= '0;
            lfsr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wcnt_q  <= wcnt_d;
            lfsr_q  <= lfsr_d;
        end
    end

    assign lfsr_flat    = lfsr_q;
    assign ZxDO         = lfsr_flat[NUM_Z-1:0];
    assign SeedReadyxSO = (state_q == StSeed);
    assign ZValidxSO    = (state_q == StRun);

endmodule
